// File: rtl/context_switch_engine.sv
// Bulk register-bank <-> memory mover for OS context switches (SAVE / RESTORE of one 64-word frame).
// Optional frame checksum in word 0 is enabled by defining CTX_CHECKSUM_EN.
module context_switch_engine #(
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 63,
  parameter int CTX_WIDTH  = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Slow_Clock,
  input  logic                  Reset,
  input  logic                  Start_Save,
  input  logic                  Start_Restore,
  input  logic [CTX_WIDTH-1:0]  Ctx_Id,
  output logic                  Busy,
  output logic                  Done,
  output logic [5:0]            Reg_Sel,
  input  logic [31:0]           Reg_Data,
  output logic                  Reg_Write,
  output logic [5:0]            Reg_Wr_Sel,
  output logic [31:0]           Reg_Wr_Data,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic                  Mem_Write,
  output logic [31:0]           Mem_Data_Out,
  input  logic [31:0]           Mem_Data_In,
  output logic                  Ctx_Error
);

  typedef enum logic [2:0] {S_IDLE, S_SAVE, S_RESTORE, S_DRAIN, S_DONE, S_CKSUM} state_t;

  localparam logic [5:0] FIRST = 6'(FIRST_REG);
  localparam logic [5:0] LAST  = 6'(LAST_REG);
`ifdef CTX_CHECKSUM_EN
  localparam logic [5:0] RST_START = 6'd0;  // restore fetches the checksum word first
`else
  localparam logic [5:0] RST_START = FIRST;
`endif

  state_t               state_q, state_d;
  logic [5:0]           idx_q, idx_d, prev_q, prev_d;
  logic                 pend_q, pend_d, wr_stage;
  logic [CTX_WIDTH-1:0] ctx_q, ctx_d;
`ifdef CTX_CHECKSUM_EN
  logic [31:0]          xor_q, xor_d, ck_q, ck_d;
  logic                 err_q, err_d;
`endif

  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      prev_q  <= '0;
      pend_q  <= 1'b0;
      ctx_q   <= '0;
`ifdef CTX_CHECKSUM_EN
      xor_q   <= '0;
      ck_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      ctx_q   <= ctx_d;
`ifdef CTX_CHECKSUM_EN
      xor_q   <= xor_d;
      ck_q    <= ck_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prev_d       = prev_q;
    pend_d       = pend_q;
    ctx_d        = ctx_q;
    wr_stage     = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    Reg_Sel      = '0;
    Reg_Write    = 1'b0;
    Reg_Wr_Sel   = '0;
    Reg_Wr_Data  = '0;
    Mem_Addr     = '0;
    Mem_Write    = 1'b0;
    Mem_Data_Out = '0;
`ifdef CTX_CHECKSUM_EN
    xor_d        = xor_q;
    ck_d         = ck_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start_Save || Start_Restore) begin
          ctx_d   = Ctx_Id;
          pend_d  = 1'b0;
          idx_d   = Start_Save ? FIRST : RST_START;
          state_d = Start_Save ? S_SAVE : S_RESTORE;
`ifdef CTX_CHECKSUM_EN
          xor_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_SAVE: begin
        Busy         = 1'b1;
        Reg_Sel      = idx_q;
        Mem_Write    = 1'b1;
        Mem_Data_Out = Reg_Data;
        Mem_Addr[CTX_WIDTH+5:0] = {ctx_q, idx_q};
        idx_d        = idx_q + 6'd1;
`ifdef CTX_CHECKSUM_EN
        xor_d        = xor_q ^ Reg_Data;
        if (idx_q == LAST) state_d = S_CKSUM;
`else
        if (idx_q == LAST) state_d = S_DONE;
`endif
      end
      S_CKSUM: begin
        Busy      = 1'b1;
        Mem_Write = 1'b1;
`ifdef CTX_CHECKSUM_EN
        Mem_Data_Out = xor_q;
`endif
        Mem_Addr[CTX_WIDTH+5:0] = {ctx_q, 6'd0};
        state_d   = S_DONE;
      end
      S_RESTORE: begin
        Busy     = 1'b1;
        wr_stage = 1'b1;
        Mem_Addr[CTX_WIDTH+5:0] = {ctx_q, idx_q};
        pend_d   = 1'b1;
        prev_d   = idx_q;
        idx_d    = (idx_q == 6'd0) ? FIRST : idx_q + 6'd1;
        if (idx_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        Busy     = 1'b1;
        wr_stage = 1'b1;
        pend_d   = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Write-back half of the restore pipeline: data for the previously issued index.
    if (wr_stage && pend_q) begin
      if (prev_q != 6'd0) begin
        Reg_Write   = 1'b1;
        Reg_Wr_Sel  = prev_q;
        Reg_Wr_Data = Mem_Data_In;
`ifdef CTX_CHECKSUM_EN
        xor_d       = xor_q ^ Mem_Data_In;
`endif
      end
`ifdef CTX_CHECKSUM_EN
      else ck_d = Mem_Data_In;
`endif
    end
`ifdef CTX_CHECKSUM_EN
    if (state_q == S_DRAIN) err_d = (xor_d != ck_q);
`endif
  end

`ifdef CTX_CHECKSUM_EN
  assign Ctx_Error = err_q;
`else
  assign Ctx_Error = 1'b0;
`endif

endmodule

// File: tb/tb_context_switch_engine.sv
// Self-checking bench: two engines (full range and single-register range) with behavioural bank/memory
// and a frame-level reference model.
module tb_context_switch_engine;
  localparam int CW = 4;
  localparam int AW = 10;
`ifdef CTX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] ss, sr, busy, done, rw, mw, cerr;
  logic [1:0][CW-1:0] cid;
  logic [1:0][5:0] rsel, wsel;
  logic [1:0][31:0] rdata, wdata, mdout, mdin;
  logic [1:0][AW-1:0] maddr;

  logic [31:0] bank [2][64];
  logic [31:0] mem  [2][1024];
  int memw_cnt [2];
  int regw_cnt [2];
  int done_cnt [2];
  int zero_wr, excl_viol;

  logic tb_we, tb_mem;
  int tb_d, tb_addr;
  logic [31:0] tb_data;

  // reference model: expected frame contents per engine / context
  logic [31:0] mf  [2][16][64];
  logic [31:0] mw0 [2][16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  context_switch_engine #(.FIRST_REG(1), .LAST_REG(63), .CTX_WIDTH(CW), .ADDR_WIDTH(AW)) u_dut0 (
    .Slow_Clock(clk), .Reset(rst), .Start_Save(ss[0]), .Start_Restore(sr[0]), .Ctx_Id(cid[0]),
    .Busy(busy[0]), .Done(done[0]), .Reg_Sel(rsel[0]), .Reg_Data(rdata[0]), .Reg_Write(rw[0]),
    .Reg_Wr_Sel(wsel[0]), .Reg_Wr_Data(wdata[0]), .Mem_Addr(maddr[0]), .Mem_Write(mw[0]),
    .Mem_Data_Out(mdout[0]), .Mem_Data_In(mdin[0]), .Ctx_Error(cerr[0]));

  context_switch_engine #(.FIRST_REG(5), .LAST_REG(5), .CTX_WIDTH(CW), .ADDR_WIDTH(AW)) u_dut1 (
    .Slow_Clock(clk), .Reset(rst), .Start_Save(ss[1]), .Start_Restore(sr[1]), .Ctx_Id(cid[1]),
    .Busy(busy[1]), .Done(done[1]), .Reg_Sel(rsel[1]), .Reg_Data(rdata[1]), .Reg_Write(rw[1]),
    .Reg_Wr_Sel(wsel[1]), .Reg_Wr_Data(wdata[1]), .Mem_Addr(maddr[1]), .Mem_Write(mw[1]),
    .Mem_Data_Out(mdout[1]), .Mem_Data_In(mdin[1]), .Ctx_Error(cerr[1]));

  always_comb begin
    for (int d = 0; d < 2; d++) rdata[d] = bank[d][rsel[d]];
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mdin[d] <= mem[d][maddr[d]];
      if (mw[d]) begin
        mem[d][maddr[d]] <= mdout[d];
        memw_cnt[d] <= memw_cnt[d] + 1;
      end
      if (rw[d]) begin
        bank[d][wsel[d]] <= wdata[d];
        regw_cnt[d] <= regw_cnt[d] + 1;
        if (wsel[d] == 6'd0) zero_wr <= zero_wr + 1;
        if (mw[d]) excl_viol <= excl_viol + 1;
      end
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
    if (tb_we) begin
      if (tb_mem) mem[tb_d][tb_addr] <= tb_data;
      else        bank[tb_d][tb_addr] <= tb_data;
    end
  end

  function automatic int fr(input int d); return (d == 0) ? 1 : 5; endfunction
  function automatic int lr(input int d); return (d == 0) ? 63 : 5; endfunction
  function automatic int nr(input int d); return lr(d) - fr(d) + 1; endfunction

  function automatic logic [31:0] fxor(input int d, input int ctx);
    logic [31:0] x = '0;
    for (int i = fr(d); i <= lr(d); i++) x ^= mf[d][ctx][i];
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int d, input logic is_mem, input int addr, input logic [31:0] data);
    @(negedge clk);
    tb_we = 1'b1; tb_mem = is_mem; tb_d = d; tb_addr = addr; tb_data = data;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic load_bank(input int d, input int mode);  // 0 random, 1 i*3, 2 zero
    for (int i = 0; i < 64; i++)
      poke(d, 1'b0, i, (i == 0) ? SENT : (mode == 1) ? 32'(i * 3) : (mode == 2) ? 32'h0 : $urandom);
  endtask

  task automatic do_op(input int d, input bit save, input bit both, input bit mid, input int ctx,
                       output int cyc);
    @(negedge clk);
    cid[d] = ctx[CW-1:0];
    ss[d] = save | both;
    sr[d] = ~save | both;
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      ss[d] = 1'b0;
      sr[d] = (mid && cyc == 20);
      if (cyc == 2 && !done[d]) chk("busy_active", busy[d], 1'b1);
      if (done[d]) break;
    end
    chk("busy_in_done", busy[d], 1'b0);
  endtask

  task automatic save_chk(input int d, input int ctx, input bit both, input bit mid);
    logic [31:0] snap [64];
    logic [31:0] pre0;
    int m0, r0, cyc, bad;
    for (int i = 0; i < 64; i++) snap[i] = bank[d][i];
    pre0 = mem[d][ctx * 64];
    m0 = memw_cnt[d]; r0 = regw_cnt[d];
    do_op(d, 1'b1, both, mid, ctx, cyc);
    for (int i = fr(d); i <= lr(d); i++) mf[d][ctx][i] = snap[i];
    mw0[d][ctx] = CK ? fxor(d, ctx) : pre0;
    chk("save_cycles", 64'(cyc), 64'(nr(d) + 1 + CK));
    chk("save_memw", 64'(memw_cnt[d] - m0), 64'(nr(d) + CK));
    chk("save_regw", 64'(regw_cnt[d] - r0), 64'd0);
    bad = 0;
    for (int i = fr(d); i <= lr(d); i++) if (mem[d][ctx * 64 + i] !== mf[d][ctx][i]) bad++;
    chk("save_frame", 64'(bad), 64'd0);
    chk("save_word0", {32'h0, mem[d][ctx * 64]}, {32'h0, mw0[d][ctx]});
  endtask

  task automatic restore_chk(input int d, input int ctx);
    logic [31:0] pre [64];
    logic [31:0] exp;
    int m0, r0, cyc, bad;
    for (int i = 0; i < 64; i++) pre[i] = bank[d][i];
    m0 = memw_cnt[d]; r0 = regw_cnt[d];
    do_op(d, 1'b0, 1'b0, 1'b0, ctx, cyc);
    chk("rest_cycles", 64'(cyc), 64'(nr(d) + 2 + CK));
    chk("rest_regw", 64'(regw_cnt[d] - r0), 64'(nr(d)));
    chk("rest_memw", 64'(memw_cnt[d] - m0), 64'd0);
    chk("rest_err", cerr[d], (CK != 0) && (fxor(d, ctx) != mw0[d][ctx]));
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      exp = (i >= fr(d) && i <= lr(d)) ? mf[d][ctx][i] : pre[i];
      if (bank[d][i] !== exp) bad++;
    end
    chk("rest_bank", 64'(bad), 64'd0);
    chk("rest_reg0", {32'h0, bank[d][0]}, {32'h0, SENT});
  endtask

  initial begin
    int cyc, dc0, ctx;
    rst = 1'b1; ss = '0; sr = '0; cid = '0; tb_we = 1'b0; tb_mem = 1'b0; tb_d = 0; tb_addr = 0; tb_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_memw", mw, 2'b00);
    chk("rst_regw", rw, 2'b00);
    chk("rst_addr", maddr[0], '0);
    chk("rst_rsel", rsel[0], '0);
    chk("rst_err", cerr, 2'b00);
    rst = 1'b0;

    // Test-plan save/restore of context 2 with R[i]=i*3
    load_bank(0, 1);
    save_chk(0, 2, 1'b0, 1'b0);
    chk("plan_addr129", {32'h0, mem[0][129]}, 64'd3);
    chk("plan_addr191", {32'h0, mem[0][191]}, 64'd189);
    load_bank(0, 2);
    restore_chk(0, 2);
    chk("plan_r63", {32'h0, bank[0][63]}, 64'd189);

    // Simultaneous starts and an ignored mid-save restore request
    load_bank(0, 0);
    save_chk(0, 5, 1'b1, 1'b0);
    load_bank(0, 0);
    save_chk(0, 6, 1'b0, 1'b1);

    // Random save/scramble/restore rounds
    for (int k = 0; k < 3; k++) begin
      ctx = $urandom_range(7, 15);
      load_bank(0, 0);
      save_chk(0, ctx, 1'b0, 1'b0);
      load_bank(0, 0);
      restore_chk(0, ctx);
    end
    load_bank(0, 0);
    restore_chk(0, 5);

    // Reset at the 10th save cycle aborts without Done
    @(negedge clk);
    cid[0] = 4'd4; ss[0] = 1'b1;
    @(posedge clk); #1; ss[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    dc0 = done_cnt[0];
    @(posedge clk); #1;
    chk("abort_memw", mw[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_nodone", 64'(done_cnt[0] - dc0), 64'd0);
    load_bank(0, 0);
    save_chk(0, 4, 1'b0, 1'b0);
    load_bank(0, 0);
    restore_chk(0, 4);

    // Single-register range engine
    load_bank(1, 0);
    save_chk(1, 3, 1'b0, 1'b0);
    load_bank(1, 0);
    restore_chk(1, 3);

`ifdef CTX_CHECKSUM_EN
    // Corrupt word 7 of a saved frame; restore must flag it and hold the flag
    poke(0, 1'b1, 4 * 64 + 7, mem[0][4 * 64 + 7] ^ 32'h0000_0100);
    mf[0][4][7] = mf[0][4][7] ^ 32'h0000_0100;
    load_bank(0, 0);
    restore_chk(0, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("err_hold", cerr[0], 1'b1);
    restore_chk(0, 5);
`endif

    chk("strobe_excl", 64'(excl_viol), 64'd0);
    chk("no_reg0_write", 64'(zero_wr), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
